// File: rtl/sfpp_link_supervisor.sv
// SFP+ link bring-up supervisor: a Wishbone classic initiator that probes the
// control slave, cycles transceiver reset, waits for lock and watches the link.
module sfpp_link_supervisor #(
    parameter int HOLD_CYCLES   = 1024,
    parameter int POLL_INTERVAL = 256,
    parameter int LOCK_TIMEOUT  = 1048576,
    parameter int ACK_TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        loopback,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [7:0]  wb_adr,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack,
    output logic        link_up,
    output logic [3:0]  state,
    output logic [7:0]  retry_count,
    output logic        absent,
    output logic        bus_error
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_PROBE      = 4'd1;
    localparam logic [3:0] S_ASSERT_RST = 4'd2;
    localparam logic [3:0] S_HOLD       = 4'd3;
    localparam logic [3:0] S_RELEASE    = 4'd4;
    localparam logic [3:0] S_WAIT_GT    = 4'd5;
    localparam logic [3:0] S_WAIT_PHY   = 4'd6;
    localparam logic [3:0] S_UP         = 4'd7;
    localparam logic [3:0] S_ABSENT     = 4'd8;

    localparam logic [7:0] ADR_PRESENCE    = 8'h00;
    localparam logic [7:0] ADR_XCVR_STATUS = 8'h04;
    localparam logic [7:0] ADR_XCVR_CTRL   = 8'h08;
    localparam logic [7:0] ADR_PHY_STATUS  = 8'h0C;
    localparam logic [7:0] ADR_PHY_CTRL    = 8'h10;

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int PW = $clog2(POLL_INTERVAL + 1);
    localparam int LW = $clog2(LOCK_TIMEOUT + 1);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_INTERVAL - 1);
    localparam logic [LW-1:0] LOCK_MAX  = LW'(LOCK_TIMEOUT);
    localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic gt_ready(input logic [31:0] d);
        return d[4] & d[7] & d[11];
    endfunction

    function automatic logic phy_locked(input logic [31:0] d);
        return d[0] & ~d[1];
    endfunction

    logic [3:0]    state_r;
    logic          step_r;
    logic [HW-1:0] hold_cnt_r;
    logic [PW-1:0] poll_cnt_r;
    logic [LW-1:0] lock_tmr_r;
    logic [AW-1:0] ack_tmr_r;
    logic          wb_cyc_r;
    logic          wb_stb_r;
    logic          wb_we_r;
    logic [7:0]    wb_adr_r;
    logic [31:0]   wb_dat_o_r;
    logic          link_up_r;
    logic [7:0]    retry_count_r;
    logic          absent_r;
    logic          bus_error_r;

    logic          done_s;
    logic          tmo_s;
    logic          poll_due_s;
    logic          lock_exp_s;
    logic          issue_s;
    logic          req_we_s;
    logic [7:0]    req_adr_s;
    logic [31:0]   req_dat_s;

    assign done_s     = wb_cyc_r & wb_ack;
    assign tmo_s      = wb_cyc_r & ~wb_ack & (ack_tmr_r == ACK_LAST);
    assign poll_due_s = (poll_cnt_r == POLL_LAST);
    assign lock_exp_s = (lock_tmr_r == LOCK_MAX);

    // Decode which access the current state wants and whether to launch it now
    always_comb begin
        req_we_s  = 1'b0;
        req_adr_s = ADR_PRESENCE;
        req_dat_s = 32'h0000_0000;
        case (state_r)
            S_ASSERT_RST: begin
                req_we_s = 1'b1;
                if (step_r == 1'b0) begin
                    req_adr_s = ADR_XCVR_CTRL;
                    req_dat_s = 32'h0000_0001;
                end else begin
                    req_adr_s = ADR_PHY_CTRL;
                    req_dat_s = {31'b0, loopback};
                end
            end
            S_RELEASE: begin
                req_we_s  = 1'b1;
                req_adr_s = ADR_XCVR_CTRL;
            end
            S_WAIT_GT:             req_adr_s = ADR_XCVR_STATUS;
            S_WAIT_PHY, S_UP:      req_adr_s = ADR_PHY_STATUS;
            default:               req_adr_s = ADR_PRESENCE;
        endcase

        issue_s = 1'b0;
        if (!wb_cyc_r && enable) begin
            case (state_r)
                S_PROBE, S_ASSERT_RST, S_RELEASE: issue_s = 1'b1;
                S_WAIT_GT, S_WAIT_PHY:            issue_s = poll_due_s & ~lock_exp_s;
                S_UP:                             issue_s = poll_due_s;
                default:                          issue_s = 1'b0;
            endcase
        end else begin
            issue_s = 1'b0;
        end
    end

    // Wishbone engine: one access at a time, strobes drop the cycle after ack or timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_cyc_r   <= 1'b0;
            wb_stb_r   <= 1'b0;
            wb_we_r    <= 1'b0;
            wb_adr_r   <= 8'h00;
            wb_dat_o_r <= 32'h0000_0000;
            ack_tmr_r  <= '0;
        end else if (done_s || tmo_s) begin
            wb_cyc_r <= 1'b0;
            wb_stb_r <= 1'b0;
            wb_we_r  <= 1'b0;
        end else if (issue_s) begin
            wb_cyc_r   <= 1'b1;
            wb_stb_r   <= 1'b1;
            wb_we_r    <= req_we_s;
            wb_adr_r   <= req_adr_s;
            wb_dat_o_r <= req_dat_s;
            ack_tmr_r  <= '0;
        end else if (wb_cyc_r) begin
            ack_tmr_r <= ack_tmr_r + AW'(1);
        end
    end

    // Bring-up sequencer; access results are consumed on the ack edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            step_r        <= 1'b0;
            hold_cnt_r    <= '0;
            poll_cnt_r    <= '0;
            lock_tmr_r    <= '0;
            link_up_r     <= 1'b0;
            retry_count_r <= 8'd0;
            absent_r      <= 1'b0;
            bus_error_r   <= 1'b0;
        end else begin
            if ((state_r == S_WAIT_GT || state_r == S_WAIT_PHY) && !lock_exp_s) begin
                lock_tmr_r <= lock_tmr_r + LW'(1);
            end
            if (tmo_s) begin
                bus_error_r   <= 1'b1;
                retry_count_r <= sat_inc(retry_count_r);
                link_up_r     <= 1'b0;
                step_r        <= 1'b0;
                poll_cnt_r    <= '0;
                state_r       <= enable ? S_ASSERT_RST : S_IDLE;
            end else if (done_s && !enable) begin
                state_r    <= S_IDLE;
                link_up_r  <= 1'b0;
                absent_r   <= 1'b0;
                step_r     <= 1'b0;
                poll_cnt_r <= '0;
            end else if (done_s) begin
                poll_cnt_r <= '0;
                case (state_r)
                    S_PROBE: begin
                        if (wb_dat_i == 32'h0000_0001) begin
                            state_r <= S_ASSERT_RST;
                            step_r  <= 1'b0;
                        end else begin
                            absent_r <= 1'b1;
                            state_r  <= S_ABSENT;
                        end
                    end
                    S_ASSERT_RST: begin
                        if (step_r == 1'b0) begin
                            step_r <= 1'b1;
                        end else begin
                            step_r     <= 1'b0;
                            hold_cnt_r <= '0;
                            state_r    <= S_HOLD;
                        end
                    end
                    S_RELEASE: begin
                        lock_tmr_r <= '0;
                        state_r    <= S_WAIT_GT;
                    end
                    S_WAIT_GT: begin
                        if (gt_ready(wb_dat_i)) state_r <= S_WAIT_PHY;
                    end
                    S_WAIT_PHY: begin
                        if (phy_locked(wb_dat_i)) begin
                            link_up_r <= 1'b1;
                            state_r   <= S_UP;
                        end
                    end
                    S_UP: begin
                        if (!phy_locked(wb_dat_i)) begin
                            link_up_r     <= 1'b0;
                            retry_count_r <= sat_inc(retry_count_r);
                            step_r        <= 1'b0;
                            state_r       <= S_ASSERT_RST;
                        end
                    end
                    default: state_r <= S_IDLE;
                endcase
            end else if (wb_cyc_r) begin
                state_r <= state_r;
            end else if (!enable) begin
                state_r    <= S_IDLE;
                link_up_r  <= 1'b0;
                absent_r   <= 1'b0;
                step_r     <= 1'b0;
                hold_cnt_r <= '0;
                poll_cnt_r <= '0;
                lock_tmr_r <= '0;
            end else begin
                case (state_r)
                    S_IDLE: state_r <= S_PROBE;
                    S_HOLD: begin
                        if (hold_cnt_r == HOLD_LAST) begin
                            state_r <= S_RELEASE;
                        end else begin
                            hold_cnt_r <= hold_cnt_r + HW'(1);
                        end
                    end
                    S_WAIT_GT, S_WAIT_PHY, S_UP: begin
                        if (state_r != S_UP && lock_exp_s) begin
                            retry_count_r <= sat_inc(retry_count_r);
                            step_r        <= 1'b0;
                            poll_cnt_r    <= '0;
                            state_r       <= S_ASSERT_RST;
                        end else if (poll_due_s) begin
                            poll_cnt_r <= '0;
                        end else begin
                            poll_cnt_r <= poll_cnt_r + PW'(1);
                        end
                    end
                    S_PROBE, S_ASSERT_RST, S_RELEASE, S_ABSENT: state_r <= state_r;
                    default: state_r <= S_IDLE;
                endcase
            end
        end
    end

    assign wb_cyc      = wb_cyc_r;
    assign wb_stb      = wb_stb_r;
    assign wb_we       = wb_we_r;
    assign wb_adr      = wb_adr_r;
    assign wb_dat_o    = wb_dat_o_r;
    assign link_up     = link_up_r;
    assign state       = state_r;
    assign retry_count = retry_count_r;
    assign absent      = absent_r;
    assign bus_error   = bus_error_r;

endmodule
